// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage: operand bundle,
// register selector width and the writeback forwarding helper.
package operand_fetch_pkg;
   localparam int XLEN      = 32;
   localparam int NREGS     = 32;
   localparam int REG_SEL_W = 5;

   typedef logic [REG_SEL_W-1:0] reg_sel_t;

   localparam reg_sel_t REG_ZERO = 5'd0;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      reg_sel_t        rd;
      logic            rd_we;
   } op_bundle_t;

   // x0 always reads zero; a same-cycle writeback beats the bank's stale read.
   function automatic logic [XLEN-1:0] fwd_operand(
      input reg_sel_t        rs,
      input logic [XLEN-1:0] bank_data,
      input logic            wb_we,
      input reg_sel_t        wb_sel,
      input logic [XLEN-1:0] wb_data
   );
      if (rs == REG_ZERO)
         return '0;
      else if (wb_we && (wb_sel == rs))
         return wb_data;
      else
         return bank_data;
   endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// Bundled issue, register-bank, writeback and execute-side signals of operand_fetch.
interface operand_fetch_if;
   import operand_fetch_pkg::*;

   logic            issue_valid;
   logic            issue_ready;
   reg_sel_t        issue_rs1;
   reg_sel_t        issue_rs2;
   reg_sel_t        issue_rd;
   logic            issue_rd_we;
   reg_sel_t        sel_out_a;
   reg_sel_t        sel_out_b;
   logic [XLEN-1:0] data_out_a;
   logic [XLEN-1:0] data_out_b;
   logic            wb_we;
   reg_sel_t        wb_sel;
   logic [XLEN-1:0] wb_data;
   logic            flush;
   logic            op_valid;
   logic            op_ready;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   reg_sel_t        op_rd;
   logic            op_rd_we;

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
      output data_out_a, data_out_b, wb_we, wb_sel, wb_data, flush, op_ready,
      input  issue_ready, sel_out_a, sel_out_b,
      input  op_valid, op_a, op_b, op_rd, op_rd_we
   );

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
      input  data_out_a, data_out_b, wb_we, wb_sel, wb_data, flush, op_ready,
      output issue_ready, sel_out_a, sel_out_b,
      output op_valid, op_a, op_b, op_rd, op_rd_we
   );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register with
// set / writeback-clear / flush-clear and three busy lookups.
module operand_fetch_scoreboard
   import operand_fetch_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      set_en_i,
   input  reg_sel_t                  set_sel_i,
   input  logic                      clr_en_i,
   input  reg_sel_t                  clr_sel_i,
   input  logic                      fclr_en_i,
   input  reg_sel_t                  fclr_sel_i,
   input  logic [2:0][REG_SEL_W-1:0] look_sel_i,
   output logic [2:0]                busy_o
);
   logic [NREGS-1:0] pend_q, pend_d;

   // Set is applied last so a new writer outlives a same-cycle writeback.
   always_comb begin
      pend_d = pend_q;
      if (clr_en_i)  pend_d[clr_sel_i]  = 1'b0;
      if (fclr_en_i) pend_d[fclr_sel_i] = 1'b0;
      if (set_en_i)  pend_d[set_sel_i]  = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pend_q <= '0;
      else       pend_q <= pend_d;
   end

   // A writeback landing this cycle releases its register immediately.
   for (genvar g = 0; g < 3; g++) begin : g_look
      assign busy_o[g] = pend_q[look_sel_i[g]]
                       && !(clr_en_i && (clr_sel_i == look_sel_i[g]))
                       && (look_sel_i[g] != REG_ZERO);
   end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: drives bank read selectors, forwards writeback data, stalls
// RAW/WAW hazards and hands registered operand bundles to execute.
module operand_fetch
   import operand_fetch_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   operand_fetch_if.slave bus
);
   op_bundle_t op_q, op_d;
   logic       vld_q, vld_d;
   logic [2:0] busy;
   logic       hazard, slot_free, accept;
   logic       sb_set, sb_clr, sb_fclr;

   assign bus.sel_out_a = bus.issue_rs1;
   assign bus.sel_out_b = bus.issue_rs2;

   operand_fetch_scoreboard u_sb (
      .clock      (clock),
      .reset      (reset),
      .set_en_i   (sb_set),
      .set_sel_i  (bus.issue_rd),
      .clr_en_i   (sb_clr),
      .clr_sel_i  (bus.wb_sel),
      .fclr_en_i  (sb_fclr),
      .fclr_sel_i (op_q.rd),
      .look_sel_i ({bus.issue_rd, bus.issue_rs2, bus.issue_rs1}),
      .busy_o     (busy)
   );

   assign hazard          = busy[0] || busy[1] || (bus.issue_rd_we && busy[2]);
   assign slot_free       = !vld_q || bus.op_ready;
   assign bus.issue_ready = slot_free && !hazard && !bus.flush;
   assign accept          = bus.issue_valid && bus.issue_ready;

   assign sb_set  = accept && bus.issue_rd_we && (bus.issue_rd != REG_ZERO);
   assign sb_clr  = bus.wb_we && (bus.wb_sel != REG_ZERO);
   // A flushed writer will never write back, so its pending bit is dropped.
   assign sb_fclr = bus.flush && vld_q && op_q.rd_we;

   always_comb begin
      op_d  = op_q;
      vld_d = vld_q;
      if (bus.flush) begin
         vld_d = 1'b0;
      end else if (accept) begin
         vld_d      = 1'b1;
         op_d.a     = fwd_operand(bus.issue_rs1, bus.data_out_a, bus.wb_we, bus.wb_sel, bus.wb_data);
         op_d.b     = fwd_operand(bus.issue_rs2, bus.data_out_b, bus.wb_we, bus.wb_sel, bus.wb_data);
         op_d.rd    = bus.issue_rd;
         op_d.rd_we = bus.issue_rd_we;
      end else if (bus.op_ready) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q <= 1'b0;
         op_q  <= '0;
      end else begin
         vld_q <= vld_d;
         op_q  <= op_d;
      end
   end

   assign bus.op_valid = vld_q;
   assign bus.op_a     = op_q.a;
   assign bus.op_b     = op_q.b;
   assign bus.op_rd    = op_q.rd;
   assign bus.op_rd_we = op_q.rd_we;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: stimulus pushes expected bundles into a
// queue, a negedge monitor pops and compares whatever the DUT hands over.
module tb_operand_fetch;
   import operand_fetch_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   operand_fetch_if bus();

   operand_fetch dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Register bank model: combinational read, written on writeback.
   logic [XLEN-1:0] bank [NREGS];
   assign bus.data_out_a = bank[bus.sel_out_a];
   assign bus.data_out_b = bank[bus.sel_out_b];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) bank[i] <= 32'h1000 + i;
         bank[0] <= 32'hDEAD;
         bank[3] <= 32'h11;
         bank[4] <= 32'h22;
      end else if (bus.wb_we && bus.wb_sel != 0) begin
         bank[bus.wb_sel] <= bus.wb_data;
      end
   end

   int tests = 0;
   int fails = 0;
   op_bundle_t exp_q[$];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic op_bundle_t mk(input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] rd, input logic we);
      op_bundle_t r;
      r.a = a; r.b = b; r.rd = rd; r.rd_we = we;
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we);
      bus.issue_valid = 1'b1;
      bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
      bus.issue_rd = rd;   bus.issue_rd_we = we;
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0;
   endtask

   task automatic wb(input logic en, input logic [4:0] sel, input logic [31:0] d);
      bus.wb_we = en; bus.wb_sel = sel; bus.wb_data = d;
   endtask

   // Call at a negedge: checks ready and records the bundle an accept yields.
   task automatic expect_ready(input logic rdy, input op_bundle_t b);
      chk("issue_ready", {79'd0, bus.issue_ready}, {79'd0, rdy});
      if (rdy) exp_q.push_back(b);
   endtask

   // Monitor: a bundle leaves when consumed or when flushed.
   initial begin
      op_bundle_t e, act;
      forever begin
         @(negedge clock);
         if (!reset && bus.op_valid && (bus.op_ready || bus.flush)) begin
            act = mk(bus.op_a, bus.op_b, bus.op_rd, bus.op_rd_we);
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL bundle: unexpected %0h, nothing expected", act);
            end else begin
               e = exp_q.pop_front();
               chk("bundle", {10'd0, act}, {10'd0, e});
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      bus.issue_valid = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0;
      bus.issue_rd = 0; bus.issue_rd_we = 0;
      bus.flush = 0; bus.op_ready = 1;
      wb(0, 0, 0);

      @(negedge clock);
      chk("rst_op_valid", {79'd0, bus.op_valid}, 80'd0);
      chk("rst_op_a",     {48'd0, bus.op_a},     80'd0);
      chk("rst_op_b",     {48'd0, bus.op_b},     80'd0);
      chk("rst_op_rd",    {75'd0, bus.op_rd},    80'd0);
      chk("rst_op_rd_we", {79'd0, bus.op_rd_we}, 80'd0);
      tick();
      reset = 1'b0;
      tick();

      // 1: plain issue, one-cycle latency
      issue(3, 4, 1, 0);
      @(negedge clock); expect_ready(1, mk(32'h11, 32'h22, 1, 0));
      chk("sel_out_a", {75'd0, bus.sel_out_a}, 80'd3);
      tick(); idle();
      @(negedge clock);
      chk("lat_op_valid", {79'd0, bus.op_valid}, 80'd1);
      chk("idle_ready",   {79'd0, bus.issue_ready}, 80'd1);
      tick();

      // 2: RAW stall until writeback, which is forwarded
      issue(1, 2, 5, 1);
      @(negedge clock); expect_ready(1, mk(32'h1001, 32'h1002, 5, 1));
      tick(); issue(5, 0, 6, 0);
      @(negedge clock); expect_ready(0, '0);
      tick();
      @(negedge clock); expect_ready(0, '0);
      tick(); wb(1, 5, 32'hCAFE);
      @(negedge clock); expect_ready(1, mk(32'hCAFE, 32'h0, 6, 0));
      tick(); wb(0, 0, 0); idle();
      @(negedge clock); tick();

      // 3: x0 reads zero even with a writeback to x0
      wb(1, 0, 32'hFFFF); issue(0, 0, 0, 1);
      @(negedge clock); expect_ready(1, mk(32'h0, 32'h0, 0, 1));
      tick(); wb(0, 0, 0); issue(0, 0, 0, 1);
      @(negedge clock); expect_ready(1, mk(32'h0, 32'h0, 0, 1));
      tick(); idle();
      @(negedge clock); tick();

      // 4: backpressure holds the bundle, release without bubble
      bus.op_ready = 0; issue(3, 4, 10, 0);
      @(negedge clock); expect_ready(1, mk(32'h11, 32'h22, 10, 0));
      tick(); issue(4, 3, 11, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         expect_ready(0, '0);
         chk("hold_valid", {79'd0, bus.op_valid}, 80'd1);
         chk("hold_a",     {48'd0, bus.op_a},     80'h11);
         chk("hold_rd",    {75'd0, bus.op_rd},    80'd10);
         tick();
      end
      bus.op_ready = 1;
      @(negedge clock); expect_ready(1, mk(32'h22, 32'h11, 11, 0));
      tick(); idle();
      @(negedge clock);
      chk("nobubble_valid", {79'd0, bus.op_valid}, 80'd1);
      chk("nobubble_rd",    {75'd0, bus.op_rd},    80'd11);
      tick();

      // 5: flush of a held writer releases its destination
      bus.op_ready = 0; issue(1, 2, 7, 1);
      @(negedge clock); expect_ready(1, mk(32'h1001, 32'h1002, 7, 1));
      tick(); idle(); bus.flush = 1;
      @(negedge clock); expect_ready(0, '0);
      tick(); bus.flush = 0; bus.op_ready = 1; issue(7, 0, 8, 0);
      @(negedge clock);
      chk("flush_valid", {79'd0, bus.op_valid}, 80'd0);
      expect_ready(1, mk(32'h1007, 32'h0, 8, 0));
      tick(); idle();
      @(negedge clock); tick();

      // 6: new writer accepted alongside writeback to the same register stays pending
      issue(1, 2, 9, 1);
      @(negedge clock); expect_ready(1, mk(32'h1001, 32'h1002, 9, 1));
      tick(); issue(3, 4, 9, 1); wb(1, 9, 32'hBEEF);
      @(negedge clock); expect_ready(1, mk(32'h11, 32'h22, 9, 1));
      tick(); wb(0, 0, 0); issue(9, 0, 13, 0);
      @(negedge clock); expect_ready(0, '0);
      tick();
      @(negedge clock); expect_ready(0, '0);
      tick(); wb(1, 9, 32'h5555);
      @(negedge clock); expect_ready(1, mk(32'h5555, 32'h0, 13, 0));
      tick(); wb(0, 0, 0); idle();

      repeat (3) tick();
      @(negedge clock);
      chk("queue_drained", {48'd0, 32'(exp_q.size())}, 80'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
